alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
Shares the single integer ALU between the two issue lanes of the superscalar LEGv8 core. Each cycle it arbitrates round-robin between lane requests and drives the chosen operands onto the combinational ALU. It captures the ALU result and NZCV flags into a one-entry output register with a valid/ready handshake toward writeback. It also counts arbitration conflicts for performance analysis.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, ALU opcode width
TAG_W, 6, destination/ROB tag width carried with each op
CNT_W, 16, conflict counter width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
enable  input  1  global issue enable; 0 blocks new grants
req_valid  input  2  per-lane request valid (bit i = lane i)
req_ready  output  2  per-lane grant; request accepted when valid&ready
req_op  input  2*OP_W  per-lane opcode, lane i at [i*OP_W +: OP_W]
req_a  input  2*DATA_W  per-lane operand A
req_b  input  2*DATA_W  per-lane operand B (register or pre-shifted imm)
req_cin  input  2  per-lane carry in
req_tag  input  2*TAG_W  per-lane tag
alu_opcode  output  OP_W  to ALU
alu_a  output  DATA_W  to ALU
alu_b  output  DATA_W  to ALU
alu_cin  output  1  to ALU
alu_result  input  DATA_W  from ALU, combinational in same cycle
alu_nzcv  input  4  from ALU {n,z,c,v}
out_valid  output  1  result register holds data
out_ready  input  1  writeback accepts
out_result  output  DATA_W  registered result
out_nzcv  output  4  registered flags
out_tag  output  TAG_W  registered tag
out_lane  output  1  lane that issued the op
conflict_cnt  output  CNT_W  saturating conflict count

Behaviour:
- Reset: out_valid=0; out_result, out_nzcv, out_tag, out_lane = 0; rr_ptr=0; conflict_cnt=0. In-flight results are discarded. req_ready=0 during the reset cycle.
- accept = enable & (~out_valid | out_ready).
- Grant, combinational:
  - If accept=0, req_ready=00.
  - Only lane i valid: grant i.
  - Both lanes valid: grant lane rr_ptr.
  - At most one bit of req_ready is high.
- rr_ptr updates only on a grant, to ~granted_lane. No grant leaves it unchanged.
- ALU drive: alu_* = granted lane's fields. With no grant, they carry lane rr_ptr's fields, which are don't-care but deterministic.
- On a grant edge: out_valid<=1; out_result<=alu_result; out_nzcv<=alu_nzcv; out_tag<=granted tag; out_lane<=granted lane. Latency from request accept to out_valid is 1 cycle.
- Drain: out_valid&out_ready with no new grant sets out_valid<=0. Drain and grant in the same cycle keeps out_valid=1 with the new data, giving full throughput of 1 op/cycle.
- Backpressure: out_valid&~out_ready holds all out_* stable and grants nothing.
- enable=0 blocks grants only; draining still proceeds.
- Requesters must hold all fields stable while valid&~ready. The arbiter does not register requests.
- conflict_cnt increments on each cycle with req_valid=11 and a grant. It saturates at all-ones and does not wrap.
- Synchronous reset overrides all other updates in the same cycle.

Decomposition:
- Shared package (legv8_pkg):
  - ALU opcode constants (ADD, SUB, AND, ORR, EOR, LSL, LSR, ...)
  - NZCV bit-index constants
  - DATA_W and TAG_W defaults
- One sub-module, rr_arb2: a 2-way round-robin arbiter holding rr_ptr, with inputs req[1:0] and accept, and output gnt[1:0].
- Output register and counter stay in the top module.

Test Plan:
- Single lane: lane0 valid, op=ADD, a=5, b=3, tag=7, out_ready=1 -> req_ready=01; next cycle out_valid=1, out_result=8, out_tag=7, out_lane=0, nzcv=0000.
- Contention: both lanes valid continuously for 4 cycles, out_ready=1 -> grants alternate 01,10,01,10; conflict_cnt=4; throughput 1 op/cycle.
- Backpressure: out_valid=1, out_ready=0, both lanes valid for 3 cycles -> req_ready=00; out_* unchanged; rr_ptr unchanged. Raise out_ready -> drain plus grant of rr_ptr lane in the same cycle.
- Flags: SUB with a=3, b=3 -> out_nzcv=0110; SUB with a=0x7FFFFFFF, b=0xFFFFFFFF -> V=1 captured.
- Enable/reset: enable=0 with requests pending -> no grants, existing result still drains. Assert reset while out_valid=1 -> next cycle out_valid=0, conflict_cnt=0, rr_ptr=0.
- Saturation: force 2^CNT_W+3 contention cycles (CNT_W=4 build) -> conflict_cnt stays 0xF.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: ALU opcodes, NZCV flag positions and
// default datapath widths used by the execute-stage blocks.
package legv8_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;
    localparam int TAG_W_DEF  = 6;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_ORR = 4'h3,
        ALU_EOR = 4'h4,
        ALU_LSL = 4'h5,
        ALU_LSR = 4'h6,
        ALU_ASR = 4'h7
    } alu_op_e;

    // Bit positions inside the packed {n,z,c,v} flag nibble.
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the lane that wins the next
// tie and flips to the other lane after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       rr_ptr
);

    always_comb begin
        gnt = 2'b00;
        if (accept) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (|gnt) begin
            rr_ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one integer ALU between two issue lanes: round-robin grant, operand
// steering, a one-entry result register toward writeback and a conflict counter.
module alu_issue_arbiter
    import legv8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*OP_W-1:0]     req_op,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [1:0]            req_cin,
    input  logic [2*TAG_W-1:0]    req_tag,
    output logic [OP_W-1:0]       alu_opcode,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_cin,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [3:0]            alu_nzcv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [3:0]            out_nzcv,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_lane,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic              accept;
    logic [1:0]        gnt;
    logic              grant;
    logic              rr_ptr;
    logic              sel;
    logic [TAG_W-1:0]  sel_tag;
    logic              vld_p1;
    logic [DATA_W-1:0] result_p1;
    logic [3:0]        nzcv_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              lane_p1;
    logic [CNT_W-1:0]  cnt_p1;

    // Gating with reset keeps the grant quiet in the reset cycle even when the
    // result register is being drained.
    assign accept = enable & ~reset & (~vld_p1 | out_ready);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt),
        .rr_ptr (rr_ptr)
    );

    assign grant     = |gnt;
    assign sel       = grant ? gnt[1] : rr_ptr;
    assign req_ready = gnt;

    always_comb begin
        alu_opcode = sel ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
        alu_a      = sel ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
        alu_b      = sel ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
        alu_cin    = sel ? req_cin[1]                : req_cin[0];
        sel_tag    = sel ? req_tag[2*TAG_W-1:TAG_W]  : req_tag[TAG_W-1:0];
    end

    // ---- stage p1: result register toward writeback ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            nzcv_p1   <= '0;
            tag_p1    <= '0;
            lane_p1   <= 1'b0;
            cnt_p1    <= '0;
        end else begin
            if (grant) begin
                vld_p1    <= 1'b1;
                result_p1 <= alu_result;
                nzcv_p1   <= alu_nzcv;
                tag_p1    <= sel_tag;
                lane_p1   <= gnt[1];
            end else if (out_ready) begin
                vld_p1    <= 1'b0;
            end
            if (grant && (req_valid == 2'b11)) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign out_valid    = vld_p1;
    assign out_result   = result_p1;
    assign out_nzcv     = nzcv_p1;
    assign out_tag      = tag_p1;
    assign out_lane     = lane_p1;
    assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter (CNT_W=4 build): behavioural ALU, table-driven
// single-cycle vectors, multi-cycle sequences and a result scoreboard.
module tb_alu_issue_arbiter;
    import legv8_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int TW = 6;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*OW-1:0] req_op;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [1:0]      req_cin;
    logic [2*TW-1:0] req_tag;
    logic [OW-1:0]   alu_opcode;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic            alu_cin;
    logic [DW-1:0]   alu_result;
    logic [3:0]      alu_nzcv;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_result;
    logic [3:0]      out_nzcv;
    logic [TW-1:0]   out_tag;
    logic            out_lane;
    logic [CW-1:0]   conflict_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .req_tag      (req_tag),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_nzcv     (alu_nzcv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_nzcv     (out_nzcv),
        .out_tag      (out_tag),
        .out_lane     (out_lane),
        .conflict_cnt (conflict_cnt)
    );

    // Reference ALU: returns {n,z,c,v,result}.
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND: r = a & b;
            ALU_ORR: r = a | b;
            ALU_EOR: r = a ^ b;
            ALU_LSL: r = a << b[4:0];
            ALU_LSR: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_nzcv, alu_result} = alu_ref(alu_opcode, alu_a, alu_b, alu_cin);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [5:0] t0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [5:0] t1);
        req_valid = v;
        req_op    = {op1, op0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_tag   = {t1, t0};
        req_cin   = 2'b00;
    endtask

    // Scoreboard: expected writeback records pushed at grant, popped at drain.
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic [5:0]  tag;
        logic        lane;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
        end else begin
            chk("rdy_onehot", {63'd0, req_ready == 2'b11}, 64'd0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_out", {21'd0, out_result, out_nzcv, out_tag, out_lane}, {21'd0, e});
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t n;
                    logic [35:0] r;
                    r = alu_ref(req_op[i*OW +: OW], req_a[i*DW +: DW], req_b[i*DW +: DW], req_cin[i]);
                    n.res  = r[31:0];
                    n.nzcv = r[35:32];
                    n.tag  = req_tag[i*TW +: TW];
                    n.lane = i[0];
                    sbq.push_back(n);
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  vld;
        logic [3:0]  op0; logic [31:0] a0; logic [31:0] b0; logic [5:0] t0;
        logic [3:0]  op1; logic [31:0] a1; logic [31:0] b1; logic [5:0] t1;
        logic [1:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
        logic [5:0]  exp_tag;
        logic        exp_lane;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] hold_res;
        logic [5:0]  hold_tag;
        logic        hold_lane;

        // Vectors run back to back from rr_ptr=0; tie winners worked out by hand.
        vecs[0] = '{2'b01, ALU_ADD, 32'd5, 32'd3, 6'd7, ALU_ADD, 32'd0, 32'd0, 6'd0,
                    2'b01, 1'b1, 32'd8, 4'b0000, 6'd7, 1'b0};
        vecs[1] = '{2'b01, ALU_SUB, 32'd3, 32'd3, 6'd1, ALU_ADD, 32'd0, 32'd0, 6'd0,
                    2'b01, 1'b1, 32'd0, 4'b0110, 6'd1, 1'b0};
        vecs[2] = '{2'b10, ALU_ADD, 32'd0, 32'd0, 6'd0, ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 6'd2,
                    2'b10, 1'b1, 32'h8000_0000, 4'b1001, 6'd2, 1'b1};
        vecs[3] = '{2'b11, ALU_AND, 32'hF0, 32'h3C, 6'd3, ALU_ORR, 32'h1, 32'h2, 6'd4,
                    2'b01, 1'b1, 32'h30, 4'b0000, 6'd3, 1'b0};
        vecs[4] = '{2'b11, ALU_ADD, 32'd1, 32'd1, 6'd5, ALU_EOR, 32'hFF, 32'hFF, 6'd6,
                    2'b10, 1'b1, 32'd0, 4'b0100, 6'd6, 1'b1};
        vecs[5] = '{2'b10, ALU_ADD, 32'd0, 32'd0, 6'd0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 6'd9,
                    2'b10, 1'b1, 32'd0, 4'b0110, 6'd9, 1'b1};
        vecs[6] = '{2'b01, ALU_LSL, 32'd1, 32'd31, 6'd12, ALU_ADD, 32'd0, 32'd0, 6'd0,
                    2'b01, 1'b1, 32'h8000_0000, 4'b1000, 6'd12, 1'b0};
        vecs[7] = '{2'b00, ALU_ADD, 32'd4, 32'd4, 6'd13, ALU_ADD, 32'd6, 32'd6, 6'd14,
                    2'b00, 1'b0, 32'd0, 4'b0000, 6'd0, 1'b0};

        // Reset with requests pending: nothing granted, all state cleared.
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        drive(2'b11, ALU_ADD, 32'd1, 32'd2, 6'd3, ALU_ADD, 32'd4, 32'd5, 6'd6);
        #1 chk("reset_rdy", {62'd0, req_ready}, 64'd0);
        tick();
        chk("reset_out", {31'd0, out_valid, out_result}, 64'd0);
        chk("reset_meta", {53'd0, out_nzcv, out_tag, out_lane}, 64'd0);
        chk("reset_cnt", {60'd0, conflict_cnt}, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].vld, vecs[k].op0, vecs[k].a0, vecs[k].b0, vecs[k].t0,
                  vecs[k].op1, vecs[k].a1, vecs[k].b1, vecs[k].t1);
            #1 chk($sformatf("vec%0d_rdy", k), {62'd0, req_ready}, {62'd0, vecs[k].exp_rdy});
            tick();
            chk($sformatf("vec%0d_valid", k), {63'd0, out_valid}, {63'd0, vecs[k].exp_ov});
            if (vecs[k].exp_ov)
                chk($sformatf("vec%0d_out", k), {21'd0, out_result, out_nzcv, out_tag, out_lane},
                    {21'd0, vecs[k].exp_res, vecs[k].exp_nzcv, vecs[k].exp_tag, vecs[k].exp_lane});
        end
        chk("vec_cnt", {60'd0, conflict_cnt}, 64'd2);

        // Contention: four cycles of both lanes valid from a fresh reset.
        reset = 1'b1; drive(2'b00, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(2'b11, ALU_ADD, 32'd10, 32'd20, 6'd10, ALU_SUB, 32'd50, 32'd8, 6'd11);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("cont%0d_rdy", k), {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk($sformatf("cont%0d_out", k), {62'd0, out_valid, out_lane}, {62'd0, 1'b1, k[0]});
        end
        chk("cont_cnt", {60'd0, conflict_cnt}, 64'd4);
        chk("cont_last", {32'd0, out_result}, 64'd42);

        // Backpressure: result held, nothing granted, pointer frozen.
        out_ready = 1'b0;
        hold_res = out_result; hold_tag = out_tag; hold_lane = out_lane;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d_rdy", k), {62'd0, req_ready}, 64'd0);
            tick();
            chk($sformatf("bp%0d_hold", k), {24'd0, out_valid, out_result, out_tag, out_lane},
                {24'd0, 1'b1, hold_res, hold_tag, hold_lane});
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", {62'd0, req_ready}, 64'd1);
        tick();
        chk("bp_release_out", {30'd0, out_valid, out_lane, out_result}, {30'd0, 1'b1, 1'b0, 32'd30});
        drive(2'b00, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 0);
        tick();
        chk("bp_drain", {63'd0, out_valid}, 64'd0);
        chk("bp_cnt", {60'd0, conflict_cnt}, 64'd5);

        // Enable low: no grants, held result still drains.
        out_ready = 1'b0;
        drive(2'b01, ALU_ADD, 32'd100, 32'd1, 6'd20, ALU_ADD, 0, 0, 0);
        tick();
        chk("en_setup", {63'd0, out_valid}, 64'd1);
        enable = 1'b0; out_ready = 1'b1;
        drive(2'b11, ALU_ADD, 32'd7, 32'd7, 6'd21, ALU_ADD, 32'd8, 32'd8, 6'd22);
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("en%0d_rdy", k), {62'd0, req_ready}, 64'd0);
            tick();
            chk($sformatf("en%0d_valid", k), {63'd0, out_valid}, 64'd0);
        end
        chk("en_cnt", {60'd0, conflict_cnt}, 64'd5);

        // Reset while a result is held and the pointer sits at lane 1.
        enable = 1'b1; out_ready = 1'b0;
        drive(2'b01, ALU_ADD, 32'd9, 32'd9, 6'd23, ALU_ADD, 0, 0, 0);
        tick();
        chk("rst_setup", {63'd0, out_valid}, 64'd1);
        reset = 1'b1; out_ready = 1'b1;
        drive(2'b11, ALU_ADD, 32'd1, 32'd1, 6'd24, ALU_SUB, 32'd9, 32'd2, 6'd25);
        #1 chk("rst_mid_rdy", {62'd0, req_ready}, 64'd0);
        tick();
        chk("rst_mid_out", {31'd0, out_valid, out_result}, 64'd0);
        chk("rst_mid_cnt", {60'd0, conflict_cnt}, 64'd0);
        reset = 1'b0;
        #1 chk("rst_ptr_rdy", {62'd0, req_ready}, 64'd1);
        tick();

        // Saturation: 2^CW+3 further contention cycles.
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            tick();
            if (k == (1 << CW) - 2) chk("sat_reach", {60'd0, conflict_cnt}, 64'hF);
        end
        chk("sat_hold", {60'd0, conflict_cnt}, 64'hF);

        drive(2'b00, ALU_ADD, 0, 0, 0, ALU_ADD, 0, 0, 0);
        tick();
        tick();
        chk("final_idle", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
